// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage constants: NOP encoding, PC geometry, reset vector and
// the bit fields that form a GOTO/CALL target (instr[10:0] plus PCLATH[4:3]).
package instruction_fetch_pkg;

    localparam int          PC_W       = 13;
    localparam int          INSTR_W    = 14;
    localparam logic [12:0] RESET_VEC  = 13'h0000;
    localparam logic [13:0] NOP        = 14'h0000;

    localparam int JT_MSB     = 10;
    localparam int JT_LSB     = 0;
    localparam int PCLATH_MSB = 4;
    localparam int PCLATH_LSB = 3;

    // Page bits from PCLATH on top of the 11-bit in-page address.
    function automatic logic [PC_W-1:0] jump_target(
        input logic [PCLATH_MSB-PCLATH_LSB:0] page,
        input logic [JT_MSB-JT_LSB:0]         offset
    );
        return {page, offset};
    endfunction

endpackage

// File: rtl/return_stack.sv
// Circular hardware return stack; pop wins over push. With STACK_FLAGS_EN
// defined it also tracks occupancy and raises sticky overflow/underflow flags.
module return_stack #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
`ifdef STACK_FLAGS_EN
    input  logic             flag_clr,
    output logic             ovf,
    output logic             unf,
`endif
    output logic [WIDTH-1:0] pop_data
);

    localparam int SPW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SPW-1:0]   sp;
    logic [SPW-1:0]   sp_dec;

    assign sp_dec   = sp - SPW'(1);
    assign pop_data = mem[sp_dec];

    // Pointer simply wraps: a push past full overwrites the oldest slot and a
    // pop from empty returns whatever the wrapped slot holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (pop) begin
            sp <= sp_dec;
        end else if (push) begin
            mem[sp] <= push_data;
            sp      <= sp + SPW'(1);
        end
    end

`ifdef STACK_FLAGS_EN
    localparam logic [SPW:0] FULL = (SPW+1)'(DEPTH);

    logic [SPW:0] occ;

    // Clear is written first so a same-cycle set event overrides it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (flag_clr) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end
            if (pop) begin
                if (occ == '0) unf <= 1'b1;
                else           occ <= occ - 1'b1;
            end else if (push) begin
                if (occ == FULL) ovf <= 1'b1;
                else             occ <= occ + 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/instruction_fetch.sv
// PIC16 fetch stage: program counter, instruction register and return stack.
// Define STACK_FLAGS_EN to add stack_ovf / stack_unf / stack_flag_clr.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                  PC_WIDTH     = PC_W,
    parameter int                  STACK_DEPTH  = 8,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RESET_VEC)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pc_incr_en,
    input  logic                pc_j_en,
    input  logic                pc_call_en,
    input  logic                pc_ret_en,
    input  logic                instr_rd_en,
    input  logic                instr_flush,
    input  logic [4:0]          pclath,
    input  logic [INSTR_W-1:0]  prog_data,
`ifdef STACK_FLAGS_EN
    input  logic                stack_flag_clr,
    output logic                stack_ovf,
    output logic                stack_unf,
`endif
    output logic [PC_WIDTH-1:0] prog_addr,
    output logic [PC_WIDTH-1:0] pc,
    output logic [INSTR_W-1:0]  instr_current
);

    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] ret_addr;
    logic                push;

    assign target    = PC_WIDTH'(jump_target(pclath[PCLATH_MSB:PCLATH_LSB],
                                             instr_current[JT_MSB:JT_LSB]));
    assign push      = pc_call_en & ~pc_ret_en;
    assign prog_addr = pc;

    // PC already points past the instruction in the IR, so CALL pushes it as-is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      pc <= RESET_VECTOR;
        else if (pc_ret_en)              pc <= ret_addr;
        else if (pc_call_en || pc_j_en)  pc <= target;
        else if (pc_incr_en)             pc <= pc + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           instr_current <= NOP;
        else if (instr_flush) instr_current <= NOP;
        else if (instr_rd_en) instr_current <= prog_data;
    end

    return_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pc_ret_en),
        .push_data (pc),
`ifdef STACK_FLAGS_EN
        .flag_clr  (stack_flag_clr),
        .ovf       (stack_ovf),
        .unf       (stack_unf),
`endif
        .pop_data  (ret_addr)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed scenarios plus random
// strobes, each step predicted by a behavioural model and checked by a monitor.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_incr_en = 0, pc_j_en = 0, pc_call_en = 0, pc_ret_en = 0;
    logic        instr_rd_en = 0, instr_flush = 0, stack_flag_clr = 0;
    logic [4:0]  pclath = '0;
    logic [13:0] prog_data = '0;
    logic [12:0] prog_addr, pc;
    logic [13:0] instr_current;
    logic        stack_ovf, stack_unf;

    always #5 clk = ~clk;

    instruction_fetch u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_incr_en     (pc_incr_en),
        .pc_j_en        (pc_j_en),
        .pc_call_en     (pc_call_en),
        .pc_ret_en      (pc_ret_en),
        .instr_rd_en    (instr_rd_en),
        .instr_flush    (instr_flush),
        .pclath         (pclath),
        .prog_data      (prog_data),
`ifdef STACK_FLAGS_EN
        .stack_flag_clr (stack_flag_clr),
        .stack_ovf      (stack_ovf),
        .stack_unf      (stack_unf),
`endif
        .prog_addr      (prog_addr),
        .pc             (pc),
        .instr_current  (instr_current)
    );

`ifndef STACK_FLAGS_EN
    assign stack_ovf = 1'b0;
    assign stack_unf = 1'b0;
`endif

    typedef struct {
        int          pc;
        logic [13:0] ir;
        bit          ovf;
        bit          unf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: return stack as 8 slots addressed by a wrapping count.
    int          m_pc;
    logic [13:0] m_ir;
    int          m_stk[8];
    int          m_sp, m_occ;
    bit          m_ovf, m_unf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_ir = '0; m_sp = 0; m_occ = 0; m_ovf = 0; m_unf = 0;
        for (int i = 0; i < 8; i++) m_stk[i] = 0;
    endtask

    task automatic idle_inputs();
        pc_incr_en = 0; pc_j_en = 0; pc_call_en = 0; pc_ret_en = 0;
        instr_rd_en = 0; instr_flush = 0; stack_flag_clr = 0;
    endtask

    task automatic step(input bit inc, input bit j, input bit call, input bit ret,
                        input bit rd, input bit fl, input logic [13:0] data,
                        input logic [4:0] pcl, input bit clr);
        int   tgt;
        exp_t e;
        @(negedge clk);
        pc_incr_en = inc; pc_j_en = j; pc_call_en = call; pc_ret_en = ret;
        instr_rd_en = rd; instr_flush = fl; prog_data = data; pclath = pcl;
        stack_flag_clr = clr;
        tgt = int'(pcl[4:3]) * 2048 + int'(m_ir[10:0]);
`ifdef STACK_FLAGS_EN
        if (clr) begin m_ovf = 0; m_unf = 0; end
`endif
        if (ret) begin
            m_sp = (m_sp + 7) % 8;
            m_pc = m_stk[m_sp];
            if (m_occ == 0) m_unf = 1; else m_occ--;
        end else if (call) begin
            m_stk[m_sp] = m_pc;
            m_sp = (m_sp + 1) % 8;
            if (m_occ == 8) m_ovf = 1; else m_occ++;
            m_pc = tgt;
        end else if (j) begin
            m_pc = tgt;
        end else if (inc) begin
            m_pc = (m_pc + 1) % 8192;
        end
        if (fl)      m_ir = 14'h0000;
        else if (rd) m_ir = data;
        e.pc = m_pc; e.ir = m_ir; e.ovf = m_ovf; e.unf = m_unf;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pc"}, 32'(pc), 32'h0);
        chk({tag, "_ir"}, 32'(instr_current), 32'h0);
        chk({tag, "_addr"}, 32'(prog_addr), 32'h0);
        chk({tag, "_sp"}, 32'(u_dut.u_stack.sp), 32'h0);
`ifdef STACK_FLAGS_EN
        chk({tag, "_ovf"}, 32'(stack_ovf), 32'h0);
        chk({tag, "_unf"}, 32'(stack_unf), 32'h0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1 check_reset_state("reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: one registered update per edge, compared against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", 32'(pc), 32'(e.pc));
                chk("prog_addr", 32'(prog_addr), 32'(e.pc));
                chk("ir", 32'(instr_current), 32'(e.ir));
`ifdef STACK_FLAGS_EN
                chk("ovf", 32'(stack_ovf), 32'(e.ovf));
                chk("unf", 32'(stack_unf), 32'(e.unf));
`endif
            end
        end
    end

    initial begin
        model_reset();
        idle_inputs();
        #12 check_reset_state("por");
        @(negedge clk);
        rst_n = 1'b1;

        // plain fetch+increment
        step(1,0,0,0,1,0, 14'h3005, 5'b00000, 0);
        // GOTO 0x123 on page 3, then fetch from the new address
        step(0,0,0,0,1,0, 14'h2923, 5'b11000, 0);
        step(0,1,0,0,0,1, 14'h0000, 5'b11000, 0);
        step(1,0,0,0,1,0, 14'h1ABC, 5'b11000, 0);

        // CALL at 0x010 to 0x200, then RETURN to 0x011
        step(0,0,0,0,1,0, 14'h0010, 5'b00000, 0);
        step(0,1,0,0,1,0, 14'h2200, 5'b00000, 0);
        step(1,0,0,0,0,0, 14'h0000, 5'b00000, 0);
        step(0,0,1,0,0,1, 14'h0000, 5'b00000, 0);
        step(0,0,0,1,0,1, 14'h0000, 5'b00000, 0);

        // 9 nested calls pushing 1..9, then 9 returns
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            step(0,0,0,0,1,0, 14'(i), 5'b00000, 0);
            step(0,1,0,0,1,0, 14'h0100, 5'b00000, 0);
            step(0,0,1,0,0,0, 14'h0000, 5'b00000, 0);
        end
        for (int i = 0; i < 9; i++) step(0,0,0,1,0,0, 14'h0000, 5'b00000, 0);
        step(0,0,0,0,0,0, 14'h0000, 5'b00000, 1);

        // PC wrap at 0x1FFF, then simultaneous call+return
        step(0,0,0,0,1,0, 14'h07FF, 5'b11000, 0);
        step(0,1,0,0,0,0, 14'h0000, 5'b11000, 0);
        step(1,0,0,0,0,0, 14'h0000, 5'b00000, 0);
        step(0,0,1,1,0,0, 14'h0000, 5'b00000, 0);
        step(0,0,0,1,0,0, 14'h0000, 5'b00000, 0);

        // randomized strobes
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0,1), ($urandom_range(0,5) == 0), ($urandom_range(0,4) == 0),
                 ($urandom_range(0,4) == 0), $urandom_range(0,1), ($urandom_range(0,6) == 0),
                 14'($urandom), 5'($urandom), ($urandom_range(0,15) == 0));
        end

        // asynchronous reset in the middle of a cycle right after a call
        step(0,0,0,0,1,0, 14'h0050, 5'b00000, 0);
        step(0,0,1,0,0,0, 14'h0000, 5'b00000, 0);
        @(posedge clk);
        #3;
        idle_inputs();
        rst_n = 1'b0;
        #1 check_reset_state("async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1,0,0,0,1,0, 14'h0777, 5'b00000, 0);
        step(1,0,0,0,1,0, 14'h0123, 5'b00000, 0);

        @(negedge clk);
        idle_inputs();
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
